// File: rtl/serial_twos_addsub.sv
// -----------------------------------------------------------------------------
// serial_twos_addsub
//   Bit-serial two's-complement adder/subtractor for WIDTH-bit words, LSB first.
//   A word begins with start (bit 0 is consumed in that same cycle) and then
//   runs for WIDTH enabled cycles. While enable is low the word stalls.
//   Subtraction is done as a + ~b + 1: b is inverted and the carry-in is
//   preloaded with 1.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears all state and outputs
//   enable     1 = consume a bit pair this cycle, 0 = stall
//   start      marks bit 0 of a new word (only honoured with enable=1)
//   sub        sampled with start: 0 = a+b, 1 = a-b
//   a, b       serial operand bits
//   s          registered result bit
//   s_valid    one-cycle pulse when s carries a new result bit
//   last       pulses together with s_valid on the MSB
//   overflow   signed overflow of the finished word, held until the next start
//   carry_out  raw final carry of the finished word (sub: 1 = no borrow)
//   busy       high while a word is in progress
//
// Optional build macro SERIAL_ADDSUB_PAR_OUT_EN adds:
//   sum_par    [WIDTH-1:0] parallel copy of the finished word
//   par_valid  pulses with last; sum_par holds until the next last
// -----------------------------------------------------------------------------
module serial_twos_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             sub,
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic             s_valid,
    output logic             last,
    output logic             overflow,
    output logic             carry_out,
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
    output logic [WIDTH-1:0] sum_par,
    output logic             par_valid,
`endif
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            mode_q, mode_d;
    logic            s_q, s_d;
    logic            s_valid_q, s_valid_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;
    logic            cout_q, cout_d;

    // Full-adder slice. On start the word's mode and carry-in come straight
    // from sub, because bit 0 is consumed in the same cycle as start.
    logic take, fin, mode_eff, cin, bb, sum_bit, cout_bit;

    assign take     = enable && (start || state_q == RUN);
    assign fin      = enable && !start && state_q == RUN && cnt_q == LAST_CNT;
    assign mode_eff = start ? sub : mode_q;
    assign cin      = start ? sub : carry_q;
    assign bb       = b ^ mode_eff;
    assign sum_bit  = a ^ bb ^ cin;
    assign cout_bit = (a & bb) | (a & cin) | (bb & cin);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            mode_q    <= 1'b0;
            s_q       <= 1'b0;
            s_valid_q <= 1'b0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            cout_q    <= cout_d;
        end
    end

    // Next-state logic. Start always wins, so it also aborts a running word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (enable) begin
            if (start) begin
                state_d = RUN;
                cnt_d   = CW'(1);
            end else if (state_q == RUN) begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Output and datapath logic
    always_comb begin
        carry_d   = carry_q;
        mode_d    = mode_q;
        s_d       = s_q;
        s_valid_d = 1'b0;
        last_d    = 1'b0;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        if (take) begin
            s_d       = sum_bit;
            carry_d   = cout_bit;
            s_valid_d = 1'b1;
        end
        if (enable && start) begin
            mode_d = sub;
            ovf_d  = 1'b0;
            cout_d = 1'b0;
        end
        if (fin) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            last_d = 1'b1;
            ovf_d  = cin ^ cout_bit;
            cout_d = cout_bit;
        end
    end

    assign s         = s_q;
    assign s_valid   = s_valid_q;
    assign last      = last_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
    assign busy      = (state_q == RUN);

`ifdef SERIAL_ADDSUB_PAR_OUT_EN
    // Bits enter at the top and move down, so after WIDTH shifts bit 0 sits
    // at the LSB. The finished word is copied to sum_par so the shifter can
    // be reused immediately by a back-to-back word.
    logic [WIDTH-1:0] sh_q, sh_d, par_q, par_d;
    logic             pv_q;

    always_comb begin
        sh_d  = sh_q;
        par_d = par_q;
        if (take) sh_d = {sum_bit, sh_q[WIDTH-1:1]};
        if (fin)  par_d = sh_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            par_q <= '0;
            pv_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            par_q <= par_d;
            pv_q  <= fin;
        end
    end

    assign sum_par   = par_q;
    assign par_valid = pv_q;
`endif

endmodule

// File: tb/tb_serial_twos_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_addsub
//   Directed bench for serial_twos_addsub at WIDTH=8. Inputs change 1 ns after
//   a rising edge and outputs are sampled there too, so each sample shows the
//   result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_serial_twos_addsub;

    logic clk = 1'b0;
    logic reset, enable, start, sub, a, b;
    logic s, s_valid, last, overflow, carry_out, busy;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
    logic [7:0] sum_par;
    logic       par_valid;
`endif

    serial_twos_addsub #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .sub(sub),
        .a(a), .b(b), .s(s), .s_valid(s_valid), .last(last),
        .overflow(overflow), .carry_out(carry_out),
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
        .sum_par(sum_par), .par_valid(par_valid),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Observations gathered by step()
    logic [7:0] res;
    int vcnt, nlast, lastidx, stall_bad, orphan_last, par_seen;
    logic [7:0] par_word;

    task automatic clear_obs();
        res = '0; vcnt = 0; nlast = 0; lastidx = -1; stall_bad = 0;
        orphan_last = 0; par_seen = 0; par_word = '0;
    endtask

    task automatic step(input logic en, input logic st, input logic sb,
                        input logic av, input logic bv);
        enable = en; start = st; sub = sb; a = av; b = bv;
        @(posedge clk); #1;
        if (s_valid === 1'b1) begin
            if (vcnt < 8) res[vcnt] = s;
            vcnt++;
        end
        if (last === 1'b1) begin
            nlast++;
            lastidx = vcnt;
            if (s_valid !== 1'b1) orphan_last++;
        end
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
        if (par_valid === 1'b1) begin
            par_seen++;
            par_word = sum_par;
        end
`endif
    endtask

    // Drives one full word; optionally stalls for stall_len cycles after
    // bit stall_at has been consumed.
    task automatic run_word(input logic [7:0] av, input logic [7:0] bv,
                            input logic sb, input int stall_at, input int stall_len);
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, sb, av[i], bv[i]);
            if (i == stall_at) begin
                for (int j = 0; j < stall_len; j++) begin
                    step(1'b0, 1'b0, sb, ~av[i], ~bv[i]);
                    if (busy !== 1'b1 || s_valid !== 1'b0 || last !== 1'b0) stall_bad++;
                end
            end
        end
    endtask

    task automatic check_word(input string nm, input logic [7:0] exp_s,
                              input logic exp_ovf, input logic exp_cout);
        compared++;
        if (res !== exp_s) begin
            mismatched++; $display("FAIL %s_sum got %h want %h", nm, res, exp_s);
        end
        compared++;
        if (vcnt !== 8) begin
            mismatched++; $display("FAIL %s_valid_count got %0d want 8", nm, vcnt);
        end
        compared++;
        if (nlast !== 1 || lastidx !== 8 || orphan_last !== 0) begin
            mismatched++;
            $display("FAIL %s_last got count=%0d at_valid=%0d want count=1 at_valid=8", nm, nlast, lastidx);
        end
        compared++;
        if (overflow !== exp_ovf) begin
            mismatched++; $display("FAIL %s_overflow got %b want %b", nm, overflow, exp_ovf);
        end
        compared++;
        if (carry_out !== exp_cout) begin
            mismatched++; $display("FAIL %s_carry_out got %b want %b", nm, carry_out, exp_cout);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL %s_busy_after got %b want 0", nm, busy);
        end
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
        compared++;
        if (par_seen !== 1 || par_word !== exp_s) begin
            mismatched++;
            $display("FAIL %s_sum_par got %h (pulses %0d) want %h (pulses 1)", nm, par_word, par_seen, exp_s);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        compared++;
        if ({s, s_valid, last, overflow, carry_out, busy} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_outputs got %b want 000000", {s, s_valid, last, overflow, carry_out, busy});
        end
        // Idle with enable=1 and no start consumes nothing
        clear_obs();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        compared++;
        if (s_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL idle_no_consume got s_valid=%b busy=%b want 0 0", s_valid, busy);
        end
    endtask

    task automatic test_add();
        run_word(8'h05, 8'h03, 1'b0, -1, 0);
        check_word("add_05_03", 8'h08, 1'b0, 1'b0);
        run_word(8'h7F, 8'h01, 1'b0, -1, 0);
        check_word("add_7f_01", 8'h80, 1'b1, 1'b0);
        // Flags hold while idle
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        compared++;
        if (overflow !== 1'b1 || s_valid !== 1'b0) begin
            mismatched++; $display("FAIL ovf_hold got ovf=%b s_valid=%b want 1 0", overflow, s_valid);
        end
    endtask

    task automatic test_sub();
        run_word(8'h03, 8'h05, 1'b1, -1, 0);
        check_word("sub_03_05", 8'hFE, 1'b0, 1'b0);
        run_word(8'h80, 8'h01, 1'b1, -1, 0);
        check_word("sub_80_01", 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        // Word with overflow, then the next start on the very next cycle
        run_word(8'h7F, 8'h01, 1'b0, -1, 0);
        check_word("b2b_first", 8'h80, 1'b1, 1'b0);
        clear_obs();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        compared++;
        if (overflow !== 1'b0 || s_valid !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_start got ovf=%b s_valid=%b busy=%b want 0 1 1", overflow, s_valid, busy);
        end
        // Remaining bits of 0x03 - 0x05 (bit 0 already consumed)
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'h03 >> i, 8'h05 >> i);
        check_word("b2b_second", 8'hFE, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_word(8'h05, 8'h03, 1'b0, 3, 3);
        check_word("stall", 8'h08, 1'b0, 1'b0);
        compared++;
        if (stall_bad !== 0) begin
            mismatched++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad);
        end
    endtask

    task automatic test_reset_midword();
        clear_obs();
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b0, 1'b1, 1'b0);
        compared++;
        if (s !== 1'b1 || s_valid !== 1'b1 || busy !== 1'b1) begin
            mismatched++; $display("FAIL pre_reset got s=%b s_valid=%b busy=%b want 1 1 1", s, s_valid, busy);
        end
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        compared++;
        if ({s, s_valid, last, overflow, carry_out, busy} !== 6'b0) begin
            mismatched++;
            $display("FAIL midword_reset got %b want 000000", {s, s_valid, last, overflow, carry_out, busy});
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        compared++;
        if (s_valid !== 1'b0 || busy !== 1'b0 || nlast !== 0) begin
            mismatched++;
            $display("FAIL post_reset_idle got s_valid=%b busy=%b lasts=%0d want 0 0 0", s_valid, busy, nlast);
        end
        run_word(8'hFF, 8'h01, 1'b0, -1, 0);
        check_word("add_ff_01", 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        // Abort FF+01 at bit 5 with carry pending; new word must start clean
        clear_obs();
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b0, 1'b1, i == 0);
        compared++;
        if (nlast !== 0 || busy !== 1'b1) begin
            mismatched++; $display("FAIL pre_restart got lasts=%0d busy=%b want 0 1", nlast, busy);
        end
        run_word(8'h12, 8'h34, 1'b0, -1, 0);
        check_word("restart_add", 8'h46, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; start = 1'b0; sub = 1'b0; a = 1'b0; b = 1'b0;
        clear_obs();
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
